// File: rtl/riscv_pkg.sv
// Shared constants and bundle types for the 64-bit RISC-V five-stage core.
// Pipeline registers take their widths and bubble encodings from here.
package riscv_pkg;

    // Datapath widths seen by the IF/ID pipeline register.
    localparam int RV_INSTR_W = 32;
    localparam int RV_PC_W    = 64;

    // Canonical NOP: addi x0, x0, 0.
    localparam logic [RV_INSTR_W-1:0] RV_BUBBLE_INSTR = 32'h0000_0013;

    // Bundle carried from fetch into decode.
    typedef struct packed {
        logic [RV_INSTR_W-1:0] instr;
        logic [RV_PC_W-1:0]    pc;
    } if_id_t;

    // Bundle value that decode sees after a kill or a reset.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.instr = RV_BUBBLE_INSTR;
        b.pc    = '0;
        return b;
    endfunction

endpackage

// File: rtl/if_id.sv
// IF/ID pipeline register: captures the fetched instruction and its PC
// every cycle, or loads a NOP bubble with a cleared PC when IF is killed.
//
// Ports:
//   clk             - rising-edge clock
//   rst             - asynchronous active-high reset (outputs -> bubble)
//   instruction_in  - instruction from IF
//   pc              - PC of instruction_in
//   PCSrcD_Control  - taken branch/jump in decode; discards IF contents
//   flush           - pipeline flush from the hazard unit
//   instruction_out - registered instruction to ID
//   out_pc          - registered PC to ID
module if_id
    import riscv_pkg::*;
#(
    parameter int                 INSTR_W      = RV_INSTR_W,
    parameter int                 PC_W         = RV_PC_W,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = RV_BUBBLE_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic [PC_W-1:0]    pc,
    input  logic               PCSrcD_Control,
    input  logic               flush,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [PC_W-1:0]    out_pc
);

    logic               kill;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [PC_W-1:0]    pc_d, pc_q;

    // Either cause yields the same single bubble.
    assign kill = flush | PCSrcD_Control;

    always_comb begin
        instr_d = instruction_in;
        pc_d    = pc;
        if (kill) begin
            instr_d = BUBBLE_INSTR;
            pc_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= BUBBLE_INSTR;
            pc_q    <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs straight from the flops.
    assign instruction_out = instr_q;
    assign out_pc          = pc_q;

endmodule

// File: tb/tb_if_id.sv
// Self-checking bench for if_id: vector table plus scoreboarded
// streaming and hand-written reset/kill sequences.
module tb_if_id;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_in;
    logic [63:0] pc;
    logic        PCSrcD_Control;
    logic        flush;
    logic [31:0] instruction_out;
    logic [63:0] out_pc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        br;
        logic        fl;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    if_id dut (
        .clk            (clk),
        .rst            (rst),
        .instruction_in (instruction_in),
        .pc             (pc),
        .PCSrcD_Control (PCSrcD_Control),
        .flush          (flush),
        .instruction_out(instruction_out),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm,
                       input logic [31:0] ei,
                       input logic [63:0] ep);
        total++;
        if (instruction_out !== ei || out_pc !== ep) begin
            bad++;
            $display("FAIL %s: got %h/%h want %h/%h",
                     nm, instruction_out, out_pc, ei, ep);
        end
    endtask

    // Drive inputs and push the model's expectation for the next edge.
    task automatic drive(input logic [31:0] i, input logic [63:0] p,
                         input logic br, input logic fl);
        exp_t e;
        instruction_in = i;
        pc             = p;
        PCSrcD_Control = br;
        flush          = fl;
        if (br || fl) begin
            e.instr = NOP;
            e.pc    = 64'h0;
        end else begin
            e.instr = i;
            e.pc    = p;
        end
        sb.push_back(e);
    endtask

    // Clock once; compare just after the edge and again mid-cycle.
    task automatic step(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_edge"}, e.instr, e.pc);
            @(negedge clk);
            chk({nm, "_hold"}, e.instr, e.pc);
        end
    endtask

    initial begin
        vecs[0] = '{"cap0", 32'h11223344, 64'h1234567890ABCDEF,
                    1'b0, 1'b0, 32'h11223344, 64'h1234567890ABCDEF};
        vecs[1] = '{"br", 32'h11223344, 64'h1234567890ABCDEF,
                    1'b1, 1'b0, NOP, 64'h0};
        vecs[2] = '{"br_rel", 32'hDEADBEEF, 64'h4,
                    1'b0, 1'b0, 32'hDEADBEEF, 64'h4};
        vecs[3] = '{"fl", 32'hCAFEF00D, 64'h8,
                    1'b0, 1'b1, NOP, 64'h0};
        vecs[4] = '{"fl_br", 32'h0BADC0DE, 64'hC,
                    1'b1, 1'b1, NOP, 64'h0};
        vecs[5] = '{"resume", 32'hA5A5A5A5, 64'h10,
                    1'b0, 1'b0, 32'hA5A5A5A5, 64'h10};
        vecs[6] = '{"allones", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                    1'b0, 1'b0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        vecs[7] = '{"msb_pc", 32'h00000000, 64'h8000000000000001,
                    1'b0, 1'b0, 32'h00000000, 64'h8000000000000001};

        // Reset held with live inputs and a running clock.
        rst            = 1'b1;
        instruction_in = 32'h11223344;
        pc             = 64'h1234567890ABCDEF;
        PCSrcD_Control = 1'b0;
        flush          = 1'b0;
        #1;
        chk("rst_init", NOP, 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_hold", NOP, 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single-cycle vectors.
        foreach (vecs[n]) begin
            exp_t e;
            drive(vecs[n].instr, vecs[n].pc, vecs[n].br, vecs[n].fl);
            // Table expectation must agree with the scoreboard model.
            e = sb[sb.size()-1];
            sb[sb.size()-1].instr = vecs[n].e_instr;
            sb[sb.size()-1].pc    = vecs[n].e_pc;
            if (e.instr !== vecs[n].e_instr || e.pc !== vecs[n].e_pc)
                $display("note: table/model differ for %s", vecs[n].name);
            step(vecs[n].name);
        end

        // Flush held two cycles, then both, then release.
        drive(32'h1, 64'h100, 1'b0, 1'b1);
        step("fl_a");
        drive(32'h2, 64'h104, 1'b0, 1'b1);
        step("fl_b");
        drive(32'h3, 64'h108, 1'b1, 1'b1);
        step("fl_c");
        drive(32'h4, 64'h10C, 1'b0, 1'b0);
        step("fl_rel");

        // Back-to-back streaming.
        for (int i = 0; i < 20; i++) begin
            drive(32'h5000_0000 ^ (i * 32'h0101_0101) ^ $urandom,
                  64'(i) * 64'd4, 1'b0, 1'b0);
            step("stream");
        end

        // Reset asserted mid-cycle during streaming.
        drive(32'h77778888, 64'h200, 1'b0, 1'b0);
        step("pre_rst");
        instruction_in = 32'h9999AAAA;
        pc             = 64'h204;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", NOP, 64'h0);
        @(posedge clk);
        #1;
        chk("rst_edge", NOP, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rel", NOP, 64'h0);
        drive(32'hBBBBCCCC, 64'h208, 1'b0, 1'b0);
        step("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id.md
# if_id

Pipeline register between Instruction Fetch and Instruction Decode in the 64-bit RISC-V five-stage core. Each clock it captures the fetched 32-bit instruction and its 64-bit PC and presents them to decode for one cycle. When the fetched instruction must be discarded, it loads a bubble (NOP, PC cleared) instead. Causes for discarding are an explicit flush or a taken branch resolved in decode.

## Interface
- INSTR_W, 32, instruction width
- PC_W, 64, program-counter width
- BUBBLE_INSTR, 32'h0000_0013, instruction loaded on reset or flush (RISC-V `addi x0,x0,0`)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous and active-high
- instruction_in  in  INSTR_W  instruction from the IF stage
- pc  in  PC_W  PC of instruction_in
- PCSrcD_Control  in  1  taken branch/jump resolved in decode; discards the instruction currently in IF
- flush  in  1  explicit pipeline flush from the hazard unit
- instruction_out  out  INSTR_W  registered instruction to the ID stage
- out_pc  out  PC_W  registered PC to the ID stage

## Operation
- Define kill = flush | PCSrcD_Control.
- Rising clk edge with rst=0 and kill=0:
  - instruction_out <= instruction_in
  - out_pc <= pc
- Rising clk edge with rst=0 and kill=1:
  - instruction_out <= BUBBLE_INSTR
  - out_pc <= 0
  - Inputs are ignored.
- rst=1 acts immediately, without waiting for a clock:
  - instruction_out = BUBBLE_INSTR
  - out_pc = 0
  - Values are held while rst stays high; clk and all other inputs are ignored.
- Priority: rst > kill > capture.
- flush and PCSrcD_Control asserted together give the same single bubble as either one alone.
- No stall/enable input: the register loads every cycle. Stalling is handled upstream by holding the IF outputs.
- Outputs come directly from flops; there is no combinational path from any input to any output.

## Timing
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and stay stable until edge N+1.
- kill is sampled at the same edge as the data. A kill asserted during cycle N produces a bubble during cycle N+1 only. Deasserting kill restores normal capture at the very next edge.
- Reset:
  - Asserting rst mid-cycle clears the outputs at once, even between edges.
  - Deassertion is synchronized externally to clk.
  - The first capture happens at the first rising edge after rst falls.
- Reset values: instruction_out = 32'h0000_0013, out_pc = 64'h0.
- Widths are fixed; no arithmetic is performed and pc is passed through bit-exact (full 64 bits).

## Structure
- BUBBLE_INSTR and the INSTR_W/PC_W defaults go in the shared core package (`riscv_pkg`) next to the other pipeline-register constants. The module parameters default to those package values.
- Optional shared typedef `if_id_t` (instruction, pc) in the same package, for use by later pipeline registers and the hazard unit.
- Single flat module with one always_ff block; no sub-modules.

## Test plan
- Reset: hold rst=1 with instruction_in=32'h11223344 and pc=64'h1234567890ABCDEF, clock toggling. Required: outputs stay 32'h00000013 / 64'h0, and they clear immediately when rst is asserted mid-cycle.
- Normal capture: rst=0, kill=0, instruction_in=32'h11223344, pc=64'h1234567890ABCDEF before edge N. Required: after edge N, instruction_out=32'h11223344 and out_pc=64'h1234567890ABCDEF; both are unchanged until edge N+1.
- Branch kill: PCSrcD_Control=1 with the same inputs at edge N. Required: 32'h00000013 / 64'h0 after edge N. Drop PCSrcD_Control and apply instruction_in=32'hDEADBEEF, pc=64'h4 at edge N+1. Required: 32'hDEADBEEF / 64'h4.
- Flush and simultaneous kill: flush=1 alone, then flush=1 with PCSrcD_Control=1. Required: a bubble each cycle, then normal capture resumes on the first edge with both low.
- Back-to-back streaming: pc=0,4,8,… with a distinct instruction each cycle over 20 cycles. Required: outputs equal the previous cycle's inputs every cycle, with no drops or duplicates.
- Reset during streaming: assert rst between edges. Required: outputs clear immediately. Release rst. Required: the first post-reset edge captures the current inputs.
